// File: rtl/router_rx_reader.sv
// router_rx_reader: pops packets from the router FIFO and strobes header, payload and parity bytes.
// Parity checking is built only when ROUTER_RX_PARITY_CHK_EN is defined; otherwise parity_err is tied low.
module router_rx_reader (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       hold,
  output logic       read_enb,
  output logic [7:0] pkt_data,
  output logic       pkt_data_vld,
  output logic       pkt_sof,
  output logic       pkt_eof,
  output logic [5:0] pkt_len,
  output logic       parity_err,
  output logic       pkt_abort,
  output logic [7:0] pkt_count
);
  typedef enum logic [2:0] {IDLE, HDR_WAIT, PAYLOAD, PARITY_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [6:0] remaining;
  logic inflight, pop_ok, abort;
  always_comb begin
    pop_ok = vld_out && !hold && !soft_reset && !reset;
    abort = soft_reset && state != IDLE;
    read_enb = state == IDLE ? pop_ok : state == PAYLOAD ? pop_ok && remaining != 7'd0 : 1'b0;
    state_n = state;
    if (abort) state_n = IDLE;
    else case (state)
      IDLE:        state_n = read_enb ? HDR_WAIT : IDLE;
      HDR_WAIT:    state_n = PAYLOAD;
      PAYLOAD:     state_n = read_enb && remaining == 7'd1 ? PARITY_WAIT : PAYLOAD;
      PARITY_WAIT: state_n = DONE;
      default:     state_n = IDLE;
    endcase
  end
  // remaining counts pops still owed, parity byte included; the pop that empties it is the parity pop
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      inflight <= 1'b0;
      pkt_data <= '0;
      pkt_data_vld <= 1'b0;
      pkt_sof <= 1'b0;
      pkt_eof <= 1'b0;
      pkt_len <= '0;
      pkt_abort <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      inflight <= read_enb;
      pkt_data_vld <= 1'b0;
      pkt_sof <= 1'b0;
      pkt_eof <= 1'b0;
      pkt_abort <= abort;
      if (!abort) case (state)
        HDR_WAIT: begin
          pkt_data <= data_out;
          pkt_data_vld <= 1'b1;
          pkt_sof <= 1'b1;
          pkt_len <= data_out[7:2];
          remaining <= {1'b0, data_out[7:2]} + 7'd1;
        end
        PAYLOAD: begin
          if (read_enb) remaining <= remaining - 7'd1;
          if (inflight) begin
            pkt_data <= data_out;
            pkt_data_vld <= 1'b1;
          end
        end
        PARITY_WAIT: begin
          pkt_data <= data_out;
          pkt_data_vld <= 1'b1;
          pkt_eof <= 1'b1;
        end
        DONE: pkt_count <= pkt_count + 8'd1;
        default: ;
      endcase
    end
`ifdef ROUTER_RX_PARITY_CHK_EN
  logic [7:0] par;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      par <= '0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= !abort && state == PARITY_WAIT && data_out != par;
      if (state == HDR_WAIT) par <= data_out;
      else if (state == PAYLOAD && inflight) par <= par ^ data_out;
    end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_router_rx_reader.sv
// tb_router_rx_reader: FIFO model plus packet-level scoreboard for router_rx_reader.
module tb_router_rx_reader;
  logic clock = 1'b0, reset = 1'b1, vld_out = 1'b0, soft_reset = 1'b0, hold = 1'b0;
  logic [7:0] data_out = 8'h00;
  logic read_enb, pkt_data_vld, pkt_sof, pkt_eof, parity_err, pkt_abort;
  logic [7:0] pkt_data, pkt_count;
  logic [5:0] pkt_len;
`ifdef ROUTER_RX_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  router_rx_reader dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out),
    .soft_reset(soft_reset), .hold(hold), .read_enb(read_enb), .pkt_data(pkt_data),
    .pkt_data_vld(pkt_data_vld), .pkt_sof(pkt_sof), .pkt_eof(pkt_eof), .pkt_len(pkt_len),
    .parity_err(parity_err), .pkt_abort(pkt_abort), .pkt_count(pkt_count)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0, cyc = 0, vld_seen = 0, exp_cnt = 0, v0;
  logic [7:0] fifo[$];
  logic [7:0] cur[$];
  logic [10:0] exp_q[$];
  int pops[$];
  logic vld_en = 1'b1, re_q, last_perr = 1'b0;
  logic [5:0] exp_len = '0;
  logic [10:0] e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // one clock: drive FIFO flags, compare outputs at negedge, return data one cycle after a pop
  task automatic step();
    vld_out = vld_en && fifo.size() != 0;
    @(negedge clock);
    re_q = read_enb;
    if (re_q) pops.push_back(cyc);
    if (!reset) begin
      if (pkt_data_vld) begin
        vld_seen++;
        if (pkt_eof) last_perr = parity_err;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h expected no strobe", pkt_data);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'({pkt_data, pkt_sof, pkt_eof, parity_err}), 32'(e));
        end
      end else check("no_strobe", 32'({pkt_sof, pkt_eof, parity_err}), 32'd0);
      check("re_gate", 32'(read_enb && (hold || soft_reset || !vld_out)), 32'd0);
    end
    @(posedge clock);
    #1;
    cyc++;
    if (re_q && fifo.size() != 0) data_out = fifo.pop_front();
  endtask

  // packet-level model: header gets sof, last byte gets eof, parity_err from XOR of all earlier bytes
  task automatic enqueue();
    logic [7:0] x;
    logic last;
    x = 8'h00;
    for (int i = 0; i < cur.size(); i++) begin
      last = i == cur.size() - 1;
      fifo.push_back(cur[i]);
      exp_q.push_back({cur[i], i == 0, last, last && PCHK && x != cur[i]});
      x ^= cur[i];
    end
    exp_len = cur[0][7:2];
  endtask

  task automatic drain(input string name);
    int b;
    b = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && b < 400) begin
      step();
      b++;
    end
    repeat (3) step();
    check({name, "_drain"}, 32'(b < 400), 32'd1);
    check({name, "_len"}, 32'(pkt_len), 32'(exp_len));
    check({name, "_count"}, 32'(pkt_count), 32'(exp_cnt));
  endtask

  task automatic wait_pops(input int n);
    int b;
    b = 0;
    while (pops.size() < n && b < 60) begin
      step();
      b++;
    end
    check("wait_pops", 32'(pops.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state with a packet already waiting in the FIFO
    cur = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    enqueue();
    exp_cnt = 1;
    step();
    step();
    check("reset_re", 32'(read_enb), 32'd0);
    check("reset_outs", 32'({pkt_data, pkt_data_vld, pkt_sof, pkt_eof, pkt_len, parity_err, pkt_abort, pkt_count}), 32'd0);
    reset = 1'b0;
    pops.delete();
    drain("t1");
    check("t1_pops", 32'(pops.size()), 32'd5);
    check("t1_hdr_gap", 32'(pops[1] - pops[0]), 32'd2);
    check("t1_par_gap", 32'(pops[4] - pops[3]), 32'd1);
    check("t1_perr", 32'(last_perr), 32'd0);
    // bad parity byte
    cur = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDC};
    enqueue();
    exp_cnt++;
    drain("t2");
    check("t2_perr", 32'(last_perr), 32'(PCHK));
    // zero-length packet
    cur = '{8'h02, 8'h02};
    enqueue();
    exp_cnt++;
    pops.delete();
    v0 = vld_seen;
    drain("t3");
    check("t3_pops", 32'(pops.size()), 32'd2);
    check("t3_strobes", 32'(vld_seen - v0), 32'd2);
    // back-to-back packets
    cur = '{8'h05, 8'h11, 8'h14};
    enqueue();
    cur = '{8'h08, 8'h01, 8'h02, 8'h0B};
    enqueue();
    exp_cnt += 2;
    pops.delete();
    drain("t4");
    check("t4_pops", 32'(pops.size()), 32'd7);
    check("t4_b2b_gap", 32'(pops[3] - pops[2]), 32'd3);
    check("t4_perr", 32'(last_perr), 32'd0);
    // vld_out drop then hold mid-payload
    cur = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    enqueue();
    exp_cnt++;
    pops.delete();
    wait_pops(3);
    vld_en = 1'b0;
    repeat (4) step();
    check("t5_vld_pause", 32'(pops.size()), 32'd3);
    vld_en = 1'b1;
    hold = 1'b1;
    repeat (3) step();
    check("t5_hold_pause", 32'(pops.size()), 32'd3);
    hold = 1'b0;
    drain("t5");
    check("t5_pops", 32'(pops.size()), 32'd5);
    check("t5_perr", 32'(last_perr), 32'd0);
    // soft_reset during a len-10 payload
    cur = '{8'h2B, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h00};
    enqueue();
    pops.delete();
    wait_pops(4);
    soft_reset = 1'b1;
    step();
    check("t6_abort", 32'(pkt_abort), 32'd1);
    soft_reset = 1'b0;
    fifo.delete();
    exp_q.delete();
    step();
    check("t6_abort_pulse", 32'(pkt_abort), 32'd0);
    check("t6_count", 32'(pkt_count), 32'(exp_cnt));
    cur = '{8'h05, 8'h11, 8'h14};
    enqueue();
    exp_cnt++;
    pops.delete();
    step();
    check("t6_idle_pop", 32'(pops.size()), 32'd1);
    drain("t6");
    // asynchronous reset mid-payload
    cur = '{8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD};
    enqueue();
    pops.delete();
    wait_pops(3);
    #2;
    reset = 1'b1;
    #1;
    check("t7_async", 32'({read_enb, pkt_data, pkt_data_vld, pkt_sof, pkt_eof, pkt_len, parity_err, pkt_abort, pkt_count}), 32'd0);
    fifo.delete();
    exp_q.delete();
    step();
    reset = 1'b0;
    exp_cnt = 1;
    cur = '{8'h02, 8'h02};
    enqueue();
    pops.delete();
    drain("t7");
    check("t7_pops", 32'(pops.size()), 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
